// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for a combinational 256x32 instruction ROM: owns the PC,
// feeds a one-entry valid/ready stage to decode, handles redirects and halt/fault.
module imem_fetch_ctrl #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_WORD  = 32'hFFFF_FFFF,
  parameter int unsigned ADDR_LIMIT = 1024
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        halted,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  localparam logic [31:0] LIMIT = 32'(ADDR_LIMIT);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        vld_q, vld_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] opc_q, opc_d;
  logic        halted_q, halted_d;
  logic        fault_q, fault_d;
  logic [31:0] cnt_q, cnt_d;

  logic xfer, slot_free;

  assign xfer      = vld_q && out_ready;
  assign slot_free = !vld_q || out_ready;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    vld_d    = vld_q;
    instr_d  = instr_q;
    opc_d    = opc_q;
    halted_d = halted_q;
    fault_d  = fault_q;
    cnt_d    = cnt_q;

    // A word accepted by decode counts even if a redirect discards the stage.
    if (xfer) cnt_d = cnt_q + 32'd1;

    case (state_q)
      RUN: begin
        if (redirect_valid) begin
          vld_d = 1'b0;
          if (redirect_target[1:0] == 2'b00) begin
            pc_d = redirect_target;
          end else begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = HALTED;
          end
        end else if (slot_free) begin
          vld_d = 1'b0;
          if (pc_q >= LIMIT) begin
            fault_d  = 1'b1;
            halted_d = 1'b1;
            state_d  = HALTED;
          end else if (imem_rdata == HALT_WORD) begin
            // Sentinel is swallowed; pc stays pointing at it.
            halted_d = 1'b1;
            state_d  = HALTED;
          end else begin
            instr_d = imem_rdata;
            opc_d   = pc_q;
            vld_d   = 1'b1;
            pc_d    = pc_q + 32'd4;
          end
        end
      end
      HALTED: vld_d = 1'b0;
      default: state_d = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= RUN;
      pc_q     <= RESET_PC;
      vld_q    <= 1'b0;
      instr_q  <= 32'd0;
      opc_q    <= 32'd0;
      halted_q <= 1'b0;
      fault_q  <= 1'b0;
      cnt_q    <= 32'd0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      vld_q    <= vld_d;
      instr_q  <= instr_d;
      opc_q    <= opc_d;
      halted_q <= halted_d;
      fault_q  <= fault_d;
      cnt_q    <= cnt_d;
    end
  end

  assign imem_addr   = pc_q;
  assign out_valid   = vld_q;
  assign out_instr   = instr_q;
  assign out_pc      = opc_q;
  assign halted      = halted_q;
  assign fault       = fault_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Bench for imem_fetch_ctrl: ROM model plus scoreboard of words decode should accept.
module tb_imem_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] imem_addr, imem_rdata;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = 32'd0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc, fetch_count;
  logic        halted, fault;

  logic [31:0] rom [256];
  assign imem_rdata = rom[imem_addr[9:2]];

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .halted(halted), .fault(fault), .fetch_count(fetch_count)
  );

  typedef struct packed { logic [31:0] pc; logic [31:0] instr; } exp_t;
  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam logic [31:0] W0 = 32'h2008_0005, W1 = 32'h2009_0003, W2 = 32'h0109_5020;

  // Inputs change only 1 time unit after posedge, so at negedge a transfer at
  // the next edge is fully determined.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected got pc=%h instr=%h, none expected", out_pc, out_instr);
      end else begin
        e = sb.pop_front();
        if (out_pc !== e.pc || out_instr !== e.instr) begin
          failures++;
          $display("FAIL sb_word got pc=%h instr=%h exp pc=%h instr=%h", out_pc, out_instr, e.pc, e.instr);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] instr);
    exp_t e;
    e.pc = pc; e.instr = instr;
    sb.push_back(e);
  endtask

  task automatic init_rom();
    for (int i = 0; i < 256; i++) rom[i] = 32'h2000_0000 | 32'(i);
  endtask

  task automatic do_reset();
    sb.delete();
    redirect_valid = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    init_rom();
    out_ready = 1'b1;
    do_reset();
    checks += 5;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    if (halted !== 1'b0) begin failures++; $display("FAIL rst_halted got=%b exp=0", halted); end
    if (fault !== 1'b0) begin failures++; $display("FAIL rst_fault got=%b exp=0", fault); end
    if (fetch_count !== 32'd0) begin failures++; $display("FAIL rst_count got=%0d exp=0", fetch_count); end
    if (imem_addr !== 32'd0) begin failures++; $display("FAIL rst_addr got=%h exp=0", imem_addr); end
  endtask

  task automatic test_stream();
    logic [31:0] w [3];
    init_rom();
    w[0] = W0; w[1] = W1; w[2] = W2;
    rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = HALT;
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) push(32'(i * 4), w[i]);
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'(i * 4) || out_instr !== w[i]) begin
        failures++;
        $display("FAIL stream_out[%0d] got v=%b pc=%h i=%h exp v=1 pc=%h i=%h", i, out_valid, out_pc, out_instr, 32'(i * 4), w[i]);
      end
    end
    step();
    checks += 5;
    if (halted !== 1'b1) begin failures++; $display("FAIL stream_halted got=%b exp=1", halted); end
    if (out_valid !== 1'b0) begin failures++; $display("FAIL stream_valid got=%b exp=0", out_valid); end
    if (fetch_count !== 32'd3) begin failures++; $display("FAIL stream_count got=%0d exp=3", fetch_count); end
    if (fault !== 1'b0) begin failures++; $display("FAIL stream_fault got=%b exp=0", fault); end
    if (sb.size() != 0) begin failures++; $display("FAIL stream_sb_left got=%0d exp=0", sb.size()); end
    step();
    checks++;
    if (imem_addr !== 32'd12 || fetch_count !== 32'd3) begin
      failures++; $display("FAIL stream_frozen got addr=%h cnt=%0d exp addr=c cnt=3", imem_addr, fetch_count);
    end
  endtask

  task automatic test_backpressure();
    init_rom();
    rom[0] = W0; rom[1] = W1; rom[2] = W2; rom[3] = HALT;
    out_ready = 1'b0;
    do_reset();
    push(32'd0, W0); push(32'd4, W1); push(32'd8, W2);
    step();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== W0 || imem_addr !== 32'd4) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b pc=%h i=%h addr=%h exp v=1 pc=0 i=%h addr=4", i, out_valid, out_pc, out_instr, imem_addr, W0);
      end
      if (i != 3) step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_pc !== 32'd4 || out_instr !== W1) begin failures++; $display("FAIL bp_resume got pc=%h i=%h exp pc=4 i=%h", out_pc, out_instr, W1); end
    step(); step();
    checks += 2;
    if (halted !== 1'b1 || fetch_count !== 32'd3) begin failures++; $display("FAIL bp_end got h=%b cnt=%0d exp h=1 cnt=3", halted, fetch_count); end
    if (sb.size() != 0) begin failures++; $display("FAIL bp_sb_left got=%0d exp=0", sb.size()); end
  endtask

  task automatic test_redirect();
    init_rom();
    rom[4] = 32'h1111_1111; rom[5] = HALT;
    out_ready = 1'b1;
    do_reset();
    push(32'd0, rom[0]);
    step();
    step();
    checks++;
    if (out_pc !== 32'd4 || out_valid !== 1'b1) begin failures++; $display("FAIL rd_pre got pc=%h v=%b exp pc=4 v=1", out_pc, out_valid); end
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_target = 32'h10;
    push(32'h10, rom[4]);
    step();
    redirect_valid = 1'b0;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL rd_discard got=%b exp=0", out_valid); end
    if (imem_addr !== 32'h10) begin failures++; $display("FAIL rd_pc got=%h exp=10", imem_addr); end
    if (fetch_count !== 32'd1) begin failures++; $display("FAIL rd_count got=%0d exp=1", fetch_count); end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== 32'h1111_1111) begin
      failures++; $display("FAIL rd_target got v=%b pc=%h i=%h exp v=1 pc=10 i=11111111", out_valid, out_pc, out_instr);
    end
    step();
    checks++;
    if (halted !== 1'b1 || fault !== 1'b0 || fetch_count !== 32'd2) begin
      failures++; $display("FAIL rd_end got h=%b f=%b cnt=%0d exp h=1 f=0 cnt=2", halted, fault, fetch_count);
    end
  endtask

  task automatic test_misaligned();
    init_rom();
    out_ready = 1'b1;
    do_reset();
    push(32'd0, rom[0]);
    step();
    redirect_valid = 1'b1; redirect_target = 32'h6;
    step();
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd1) begin
      failures++; $display("FAIL mis_fault got f=%b h=%b v=%b cnt=%0d exp f=1 h=1 v=0 cnt=1", fault, halted, out_valid, fetch_count);
    end
    redirect_target = 32'h0;
    step(); step();
    checks++;
    if (imem_addr !== 32'd4 || out_valid !== 1'b0 || halted !== 1'b1 || fetch_count !== 32'd1) begin
      failures++; $display("FAIL mis_ignore got addr=%h v=%b h=%b cnt=%0d exp addr=4 v=0 h=1 cnt=1", imem_addr, out_valid, halted, fetch_count);
    end
    out_ready = 1'b0;
    do_reset();
    checks++;
    if (fault !== 1'b0 || halted !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'd0) begin
      failures++; $display("FAIL mis_reset got f=%b h=%b cnt=%0d addr=%h exp 0/0/0/0", fault, halted, fetch_count, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== rom[0]) begin
      failures++; $display("FAIL mis_refetch got v=%b pc=%h i=%h exp v=1 pc=0 i=%h", out_valid, out_pc, out_instr, rom[0]);
    end
  endtask

  task automatic test_addr_limit();
    init_rom();
    rom[255] = 32'hABCD_0001;
    out_ready = 1'b1;
    do_reset();
    push(32'd0, rom[0]);
    step();
    redirect_valid = 1'b1; redirect_target = 32'h3FC;
    push(32'h3FC, 32'hABCD_0001);
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_count !== 32'd1 || imem_addr !== 32'h3FC) begin
      failures++; $display("FAIL lim_redir got cnt=%0d addr=%h exp cnt=1 addr=3fc", fetch_count, imem_addr);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h3FC || out_instr !== 32'hABCD_0001 || fault !== 1'b0) begin
      failures++; $display("FAIL lim_last got v=%b pc=%h i=%h f=%b exp v=1 pc=3fc i=abcd0001 f=0", out_valid, out_pc, out_instr, fault);
    end
    step();
    checks++;
    if (fault !== 1'b1 || halted !== 1'b1 || out_valid !== 1'b0 || fetch_count !== 32'd2) begin
      failures++; $display("FAIL lim_fault got f=%b h=%b v=%b cnt=%0d exp f=1 h=1 v=0 cnt=2", fault, halted, out_valid, fetch_count);
    end
  endtask

  task automatic test_reset_midstream();
    init_rom();
    out_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 7; i++) push(32'(i * 4), rom[i]);
    for (int i = 0; i < 8; i++) step();
    checks++;
    if (out_valid !== 1'b1 || fetch_count !== 32'd7 || out_pc !== 32'd28) begin
      failures++; $display("FAIL mid_pre got v=%b cnt=%0d pc=%h exp v=1 cnt=7 pc=1c", out_valid, fetch_count, out_pc);
    end
    reset = 1'b1;
    redirect_valid = 1'b1; redirect_target = 32'h40;
    step();
    reset = 1'b0;
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    checks += 2;
    if (out_valid !== 1'b0 || fetch_count !== 32'd0 || imem_addr !== 32'd0 || halted !== 1'b0) begin
      failures++; $display("FAIL mid_reset got v=%b cnt=%0d addr=%h h=%b exp 0/0/0/0", out_valid, fetch_count, imem_addr, halted);
    end
    if (sb.size() != 0) begin failures++; $display("FAIL mid_sb_left got=%0d exp=0", sb.size()); end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'd0 || out_instr !== rom[0]) begin
      failures++; $display("FAIL mid_refetch got v=%b pc=%h i=%h exp v=1 pc=0 i=%h", out_valid, out_pc, out_instr, rom[0]);
    end
  endtask

  initial begin
    init_rom();
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_addr_limit();
    test_reset_midstream();
    out_ready = 1'b0;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
